// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;
    localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Operand request and register-file writeback bundle for muldiv_unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   Data1;
    logic [XLEN-1:0]   Data2;
    logic [REG_W-1:0]  rd_in;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   WriteData;
    logic [REG_W-1:0]  WriteReg;
    logic              RegWrite;

    modport master (
        output start, op, Data1, Data2, rd_in,
        input  busy, done, WriteData, WriteReg, RegWrite
    );

    modport slave (
        input  start, op, Data1, Data2, rd_in,
        output busy, done, WriteData, WriteReg, RegWrite
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitudes in, 32 shift-add or restoring
// steps on a shared 64-bit working register, sign fix-up and special cases last.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clock,
    input  logic    Reset,
    muldiv_if.slave bus
);

    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic [REG_W-1:0]   rd_q;
    logic [XLEN-1:0]    a_orig;
    logic [XLEN-1:0]    b_mag;
    logic [XLEN-1:0]    hi;
    logic [XLEN-1:0]    lo;
    logic               s1;
    logic               s2;
    logic [CNT_W-1:0]   cnt;

    logic               a_sgn, b_sgn;
    logic [XLEN-1:0]    a_mag, b_mag_in;
    logic [XLEN:0]      mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]    hi_nxt, lo_nxt;
    logic [2*XLEN-1:0]  prod, prod_s;
    logic [XLEN-1:0]    quo_s, rem_s, result;
    logic               div_zero;

    // Which operands are treated as signed depends on the opcode.
    always_comb begin
        a_sgn    = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU)
                   && bus.Data1[XLEN-1];
        b_sgn    = ((bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_DIV)
                   || (bus.op == OP_REM)) && bus.Data2[XLEN-1];
        a_mag    = a_sgn ? (~bus.Data1 + XLEN'(1)) : bus.Data1;
        b_mag_in = b_sgn ? (~bus.Data2 + XLEN'(1)) : bus.Data2;
    end

    // One iteration: lo holds multiplier / dividend bits, hi the upper product / remainder.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : (XLEN+1)'(0));
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, b_mag};
        if (op_q[2]) begin
            hi_nxt = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction; MIN/-1 overflow falls out of the magnitude path naturally.
    always_comb begin
        prod     = {hi, lo};
        prod_s   = (s1 ^ s2) ? (~prod + (2*XLEN)'(1)) : prod;
        quo_s    = (s1 ^ s2) ? (~lo + XLEN'(1)) : lo;
        rem_s    = s1 ? (~hi + XLEN'(1)) : hi;
        div_zero = (b_mag == '0);
        case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = div_zero ? '1 : quo_s;
            default:                      result = div_zero ? a_orig : rem_s;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            a_orig        <= '0;
            b_mag         <= '0;
            hi            <= '0;
            lo            <= '0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.RegWrite  <= 1'b0;
            bus.WriteData <= '0;
            bus.WriteReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done     <= 1'b0;
                    bus.RegWrite <= 1'b0;
                    if (bus.start) begin
                        state    <= CALC;
                        bus.busy <= 1'b1;
                        op_q     <= bus.op;
                        rd_q     <= bus.rd_in;
                        a_orig   <= bus.Data1;
                        b_mag    <= b_mag_in;
                        s1       <= a_sgn;
                        s2       <= b_sgn;
                        hi       <= '0;
                        lo       <= a_mag;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.WriteData <= result;
                    bus.WriteReg  <= rd_q;
                    bus.done      <= 1'b1;
                    bus.RegWrite  <= (rd_q != '0);
                    state         <= DONE;
                end
                default: begin
                    bus.done     <= 1'b0;
                    bus.RegWrite <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake and reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clock;
    logic Reset;
    int   errors;
    int   checks;

    muldiv_if bus();

    muldiv_unit dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one operation and observes 45 cycles after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int glitch,
                          output int lat, output int busyc, output int width,
                          output logic [31:0] d, output logic [4:0] wr, output logic rw);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = o;
        bus.Data1 = a;
        bus.Data2 = b;
        bus.rd_in = r;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.Data1 = ~a;
        bus.Data2 = ~b;
        bus.rd_in = ~r;
        bus.op    = ~o;
        lat = -1; busyc = 0; width = 0; d = 'x; wr = 'x; rw = 1'bx;
        for (int j = 0; j < 45; j++) begin
            @(negedge clock);
            if (bus.busy) busyc++;
            if (bus.done) begin
                width++;
                if (lat < 0) begin
                    lat = j;
                    d   = bus.WriteData;
                    wr  = bus.WriteReg;
                    rw  = bus.RegWrite;
                end
            end
            if (j == glitch) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.Data1 = 32'd100;
                bus.Data2 = 32'd7;
                bus.rd_in = 5'd9;
                @(posedge clock);
                #1;
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic watch_no_done(input int n, input string name);
        int seen;
        seen = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            if (bus.done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int          lat, busyc, width;
        logic [31:0] d;
        logic [4:0]  wr;
        logic        rw;
        string       tag;

        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.Data1 = '0;
        bus.Data2 = '0;
        bus.rd_in = '0;

        vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
        vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE};
        vecs[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD};
        vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        5'd7,  32'd14};
        vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        5'd8,  32'd2};
        vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF};
        vecs[9]  = '{OP_REM,    32'd5,        32'd0,        5'd10, 32'd5};
        vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000};
        vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000};
        vecs[12] = '{OP_MULH,   32'h80000000, 32'h80000000, 5'd13, 32'h40000000};
        vecs[13] = '{OP_MUL,    32'h12345678, 32'h00000010, 5'd0,  32'h23456780};
        vecs[14] = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000};
        vecs[15] = '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD};
        vecs[16] = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 5'd16, 32'h00000001};
        vecs[17] = '{OP_REM,    32'hFFFFFFFB, 32'h00000000, 5'd31, 32'hFFFFFFFB};

        // Reset state
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #2;
        check("rst_busy",     32'(bus.busy),      32'd0);
        check("rst_done",     32'(bus.done),      32'd0);
        check("rst_regwrite", 32'(bus.RegWrite),  32'd0);
        check("rst_wdata",    bus.WriteData,      32'd0);
        check("rst_wreg",     32'(bus.WriteReg),  32'd0);
        repeat (2) @(negedge clock);
        Reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, -1, lat, busyc, width, d, wr, rw);
            tag = $sformatf("v%0d", i);
            check({tag, "_data"},     d,              vecs[i].exp);
            check({tag, "_wreg"},     32'(wr),        32'(vecs[i].rd));
            check({tag, "_regwrite"}, 32'(rw),        32'(vecs[i].rd != 5'd0));
            check({tag, "_latency"},  32'(lat),       32'd33);
            check({tag, "_busy"},     32'(busyc),     32'd34);
            check({tag, "_width"},    32'(width),     32'd1);
        end

        // start pulsed mid-CALC with different operands is ignored
        run_op(OP_MUL, 32'd6, 32'd7, 5'd3, 5, lat, busyc, width, d, wr, rw);
        check("ign_data",    d,          32'd42);
        check("ign_wreg",    32'(wr),    32'd3);
        check("ign_latency", 32'(lat),   32'd33);
        check("ign_width",   32'(width), 32'd1);
        watch_no_done(40, "ign_no_second_done");

        // Reset in cycle 10 of CALC clears outputs asynchronously and aborts
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_MULHU;
        bus.Data1 = 32'hFFFFFFFF;
        bus.Data2 = 32'hFFFFFFFF;
        bus.rd_in = 5'd4;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clock);
        #2 Reset = 1'b0;
        #1;
        check("abort_busy",     32'(bus.busy),     32'd0);
        check("abort_done",     32'(bus.done),     32'd0);
        check("abort_regwrite", 32'(bus.RegWrite), 32'd0);
        check("abort_wdata",    bus.WriteData,     32'd0);
        check("abort_wreg",     32'(bus.WriteReg), 32'd0);
        repeat (2) @(negedge clock);
        Reset = 1'b1;
        watch_no_done(45, "abort_no_done");

        run_op(OP_MUL, 32'd3, 32'd4, 5'd7, -1, lat, busyc, width, d, wr, rw);
        check("post_data",     d,          32'd12);
        check("post_wreg",     32'(wr),    32'd7);
        check("post_regwrite", 32'(rw),    32'd1);
        check("post_latency",  32'(lat),   32'd33);
        check("post_busy",     32'(busyc), 32'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide execute unit implementing the RV32M operations. It sits directly downstream of `reg_file` and consumes its `Data1`/`Data2` operand outputs. It produces a `WriteData`/`WriteReg`/`RegWrite` triple that feeds straight back into the register file's write port. One operation is in flight at a time, and latency is fixed at 33 cycles from acceptance to result.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; only 32 is supported.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; accepted only on an edge where the unit is idle.
- `op`  in  3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Data1`  in  32: rs1 operand (multiplicand / dividend).
- `Data2`  in  32: rs2 operand (multiplier / divisor).
- `rd_in`  in  5: destination register, captured with the operands.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse marking a valid result.
- `WriteData`  out  32: result; holds its value until the next result.
- `WriteReg`  out  5: captured `rd_in`; holds with `WriteData`.
- `RegWrite`  out  1: equals `done` AND (`WriteReg` != 0).

## Operation
- FSM has four states: IDLE, CALC, FIX, DONE.
  - IDLE to CALC on `start`: latch `op`, `rd_in`, absolute-value operands and sign flags; clear counter.
  - CALC: one iteration per cycle, 32 iterations. Move to FIX when the counter reaches 31.
  - FIX: apply sign correction and special cases, then register the result into `WriteData`/`WriteReg`.
  - DONE: `done` is high; unconditionally return to IDLE.
- `start` is ignored in CALC, FIX and DONE. It is never queued.
- Sign handling:
  - Signed operands are: both operands for MUL/MULH/DIV/REM; rs1 only for MULHSU; neither for MULHU/DIVU/REMU.
  - The core computes on magnitudes.
  - Product sign is s1^s2.
  - Quotient sign is s1^s2; remainder sign is s1.
- Multiply: shift-add into a 64-bit accumulator. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32] after two's-complement negation of the full 64-bit value when negative.
- Divide: restoring, one quotient bit per cycle with a 33-bit partial remainder.
- Special cases are resolved in FIX, and latency stays 33 cycles:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the original rs1.
  - DIV of 0x80000000 by 0xFFFFFFFF returns 0x80000000; REM of the same returns 0.
- Reset (`Reset` low), at any time including mid-CALC:
  - State goes to IDLE; counter and accumulators clear.
  - `busy`, `done`, `RegWrite`, `WriteData` and `WriteReg` all go to 0.
  - The aborted operation produces no `done`.

## Timing
- `start` sampled high at edge N in IDLE:
  - `busy`=1 after edge N.
  - CALC occupies edges N+1 to N+32; FIX at edge N+33.
  - `done` and `RegWrite` are high for exactly the cycle between edges N+33 and N+34.
  - `busy` falls after edge N+34, so the earliest next accept is edge N+35 (next `start` must be held high from that edge on).
- Operands only need to be valid on the accept edge. Later changes on `Data1`/`Data2`/`rd_in`/`op` have no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `muldiv_pkg`:
  - `XLEN`.
  - `op` encoding constants (`OP_MUL` to `OP_REMU`).
  - FSM state typedef (IDLE/CALC/FIX/DONE).
  - Constant `ITER = 32`.
- The design is a single module, `muldiv_unit`. Multiply and divide share the counter and the 64-bit working register, so no sub-module is warranted.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD, rd=5:
  - `WriteData`=0xFFFFFFEB, `WriteReg`=5.
  - `done`/`RegWrite` pulse exactly 33 cycles after accept.
  - `busy` high 34 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULH of the same gives 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD. REM 0xFFFFFFF9/2 gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- Special cases:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
  - All at 33-cycle latency.
- Handshake:
  - `start` pulsed again during CALC with different operands is ignored; the first result is unchanged.
  - With rd=0, `done` pulses but `RegWrite` stays 0.
- `Reset` driven low at cycle 10 of CALC:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No `done` follows.
  - After release, MUL 3×4 returns 12 at normal latency.
